bf16_vec_div_seq: RTL and testbench
===================================

Name: bf16_vec_div_seq

Overview:
- N-lane bfloat16 vector divider: c1[lane] = a1[lane] / b1[lane], one shared control FSM for all lanes.
- Each lane computes its quotient with an iterative restoring mantissa divider that produces 1 bit per cycle.
- Adds what the combinational lane array lacks: valid/ready handshake, per-lane enable, per-lane exception flags and defined special-value handling.
- Sits between an operand buffer and a result consumer in the BF16 datapath.

Parameters:
- N, 4, lane count. Bus widths are 16*N; legal range 1..32.

Ports:
- clk1  in  1  clock; all logic on the rising edge.
- rst1  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand vector valid.
- in_ready  out  1  block can accept operands.
- a1  in  16*N  dividends; lane i occupies [16i+15:16i].
- b1  in  16*N  divisors; same lane packing.
- lane_en  in  N  per-lane enable; sampled on accept.
- out_valid  out  1  result vector valid.
- out_ready  in  1  consumer accepts the result.
- c1  out  16*N  quotients; same lane packing.
- flags  out  4*N  per lane, bits [4i+3:4i] = {invalid, div_by_zero, overflow, underflow}.

Behaviour:
- Reset (async assert, sync release): FSM goes to IDLE; in_ready=1, out_valid=0, c1=0, flags=0. Asserting rst1 mid-operation aborts the computation with no result.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid&&in_ready, capture a1, b1 and lane_en, then go to DIV.
  - DIV: 10 iterations (1 integer bit + 7 fraction bits + guard + round); iteration counter runs 9 down to 0, then go to NORM.
  - NORM: normalise, round, pack and apply special cases; go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- Latency: accept in cycle T, so out_valid=1 from cycle T+12. Latency is fixed and does not depend on the data.
- Throughput: one vector per 13 cycles or more. in_ready=0 in every state except IDLE.
- Handshake:
  - c1 and flags stay stable while out_valid=1 and out_ready=0.
  - out_valid falls in the cycle after the out_ready handshake.
  - in_valid asserted while busy is ignored; the upstream block holds it.
- Arithmetic, per lane:
  - Sign: sa^sb.
  - Mantissas: ma={1,fa}, mb={1,fb}, 8 bits each.
  - Quotient bits q[9:0] come from restoring division of ma by mb. Remainder is 9 bits. Sticky = |remainder after the last step.
  - Exponent: e = ea - eb + 127 in a 10-bit signed value.
  - If q[9]=0: shift left 1 and decrement e.
  - Mantissa = q[8:2]; guard and round come from the next bits.
- Rounding: truncate (round toward zero).
- Exponent range checks:
  - e >= 255: result ±inf, overflow flag set.
  - e <= 0: result ±0, underflow flag set. No subnormals are produced.
- Special cases, in priority order:
  - Either operand NaN: result 0x7FC0, invalid flag set.
  - 0/0 or inf/inf: result 0x7FC0, invalid flag set.
  - x/0 with x nonzero finite: result ±inf, div_by_zero flag set.
  - inf/x: result ±inf.
  - 0/x or x/inf: result ±0.
  - Exponent-0 (subnormal) inputs are flushed to ±0 before these checks.
- Lanes with lane_en=0: c1 lane=0x0000, flags=0. They take the same cycle count.
- All lanes finish in the same cycle; there is no per-lane early completion.

Optional Feature:
- Macro: BF16_DIV_RNE_EN.
- When defined: round to nearest-even. Round up when guard && (round || sticky || lsb).
- A mantissa carry-out re-normalises the result and increments the exponent, with the overflow check applied after the increment.
- When undefined: truncation only, and the guard/round/sticky logic is not synthesised.
- Latency and ports are identical in both builds.

Decomposition:
- Package bf16_pkg holds:
  - typedef bf16_t, a packed struct {sign, exp[7:0], frac[6:0]}.
  - typedef div_flags_t = {invalid, dz, ovf, unf}.
  - Constants: BF16_QNAN=16'h7FC0, BF16_PINF=16'h7F80, BF16_BIAS=127, DIV_ITERS=10.
  - The state enum {IDLE, DIV, NORM, DONE}.
- Top-level holds the FSM, iteration counter and handshake logic.
- Sub-module bf16_div_lane, instantiated N times via generate:
  - Datapath: operand registers, remainder and quotient shift registers, normalise/round/pack logic.
  - Control inputs from the top: load, step, finish.

Test Plan:
- Basic divide, N=4, all lanes enabled: a1 lanes {0x3F80, 0x40C0, 0x3F80, 0x3F80}, b1 lanes {0x4000, 0x4040, 0x4040, 0xC040} -> c1 lanes {0x3F00, 0x4000, 0x3EAA, 0xBEAA}, flags=0, out_valid exactly 12 cycles after accept. With BF16_DIV_RNE_EN, lanes 2 and 3 become 0x3EAB and 0xBEAB.
- Specials: 0x3F80/0x0000 -> 0x7F80, dz=1. 0x0000/0x0000 -> 0x7FC0, invalid=1. 0x7F80/0x7F80 -> 0x7FC0, invalid=1. 0x7FC1/0x3F80 -> 0x7FC0, invalid=1.
- Range: 0x7F00/0x3E80 -> 0x7F80, ovf=1. 0x0080/0x4000 -> 0x0000, unf=1.
- Handshake: hold out_ready=0 for 20 cycles -> c1 and flags stable and in_ready=0 throughout; pulse in_valid during DIV -> ignored; next accept only after out_ready.
- Lane mask: lane_en=4'b0101 -> lanes 1 and 3 give c1=0x0000 and flags=0; lanes 0 and 2 give correct quotients.
- Reset mid-DIV: assert rst1 in cycle T+5 -> out_valid=0, c1=0 and in_ready=1 immediately; no stale result after release.

Source files
------------

// File: rtl/bf16_pkg.sv
// ---------------------------------------------------------------------------
// bf16_pkg
// Shared types and constants for the sequential bfloat16 vector divider.
//   bf16_t       : packed bfloat16 word {sign, exp[7:0], frac[6:0]}
//   div_flags_t  : per-lane exception flags {invalid, dz, ovf, unf}
//   div_state_e  : control FSM encoding {IDLE, DIV, NORM, DONE}
//   BF16_QNAN / BF16_PINF / BF16_BIAS / DIV_ITERS : numeric constants
// Optional feature macro used by the lane datapath: BF16_DIV_RNE_EN
// ---------------------------------------------------------------------------
package bf16_pkg;

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [6:0] frac;
    } bf16_t;

    typedef struct packed {
        logic invalid;
        logic dz;
        logic ovf;
        logic unf;
    } div_flags_t;

    localparam logic [15:0] BF16_QNAN = 16'h7FC0;
    localparam logic [15:0] BF16_PINF = 16'h7F80;
    localparam int          BF16_BIAS = 127;
    // 1 integer bit + 7 fraction bits + guard + round
    localparam int          DIV_ITERS = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } div_state_e;

    // Exponent 0 is treated as zero: subnormal inputs are flushed.
    function automatic logic bf16_is_zero(input bf16_t x);
        return (x.exp == 8'h00);
    endfunction

    function automatic logic bf16_is_inf(input bf16_t x);
        return (x.exp == 8'hFF) && (x.frac == 7'd0);
    endfunction

    function automatic logic bf16_is_nan(input bf16_t x);
        return (x.exp == 8'hFF) && (x.frac != 7'd0);
    endfunction

endpackage

// File: rtl/bf16_div_lane.sv
// ---------------------------------------------------------------------------
// bf16_div_lane
// One bfloat16 divider lane: c = a / b using a restoring mantissa divider
// that retires one quotient bit per step, followed by a single-cycle
// normalise / round / pack / special-case stage.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   load      : capture a, b, en and initialise remainder/quotient
//   step      : perform one restoring-division iteration
//   finish    : register the packed result and flags
//   a, b, en  : operands and lane enable
//   c, flags  : registered quotient and {invalid, dz, ovf, unf}
// Build option: BF16_DIV_RNE_EN selects round-to-nearest-even instead of
// truncation.
// ---------------------------------------------------------------------------
module bf16_div_lane
    import bf16_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic        finish,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        en,
    output logic [15:0] c,
    output logic [3:0]  flags
);

    bf16_t       a_reg;
    bf16_t       b_reg;
    logic        en_reg;
    logic [8:0]  rem_reg;
    logic [8:0]  rem_next;
    logic [9:0]  q_reg;
    logic [9:0]  q_next;
    logic [15:0] c_reg;
    logic [15:0] c_next;
    div_flags_t  flags_reg;
    div_flags_t  flags_next;

    // ---------------- restoring division step ----------------
    logic [7:0] mb;
    logic [9:0] diff;
    logic       q_bit;
    logic [8:0] rem_kept;

    assign mb       = {1'b1, b_reg.frac};
    // rem < 2*mb always holds, so a borrow out of bit 9 means rem < mb.
    assign diff     = {1'b0, rem_reg} - {2'b00, mb};
    assign q_bit    = ~diff[9];
    assign rem_kept = q_bit ? diff[8:0] : rem_reg;
    // rem_kept < mb <= 255, so the shift cannot lose a set bit.
    assign rem_next = {rem_kept[7:0], 1'b0};
    assign q_next   = {q_reg[8:0], q_bit};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            en_reg    <= 1'b0;
            rem_reg   <= '0;
            q_reg     <= '0;
            c_reg     <= '0;
            flags_reg <= '0;
        end else begin
            if (load) begin
                a_reg   <= a;
                b_reg   <= b;
                en_reg  <= en;
                rem_reg <= {1'b0, 1'b1, a[6:0]};
                q_reg   <= '0;
            end else if (step) begin
                rem_reg <= rem_next;
                q_reg   <= q_next;
            end
            if (finish) begin
                c_reg     <= c_next;
                flags_reg <= flags_next;
            end
        end
    end

    // ---------------- normalise / round / pack ----------------
    logic               sign;
    logic signed [9:0]  e_raw;
    logic signed [9:0]  e_norm;
    logic [6:0]         mant;
    logic               a_zero, a_inf, a_nan;
    logic               b_zero, b_inf, b_nan;
`ifdef BF16_DIV_RNE_EN
    logic               guard;
    logic               rnd;
    logic               sticky;
`endif

    assign sign   = a_reg.sign ^ b_reg.sign;
    assign e_raw  = $signed({2'b00, a_reg.exp}) - $signed({2'b00, b_reg.exp})
                  + $signed(10'(BF16_BIAS));
    assign a_zero = bf16_is_zero(a_reg);
    assign a_inf  = bf16_is_inf(a_reg);
    assign a_nan  = bf16_is_nan(a_reg);
    assign b_zero = bf16_is_zero(b_reg);
    assign b_inf  = bf16_is_inf(b_reg);
    assign b_nan  = bf16_is_nan(b_reg);

    always_comb begin
        mant       = '0;
        e_norm     = e_raw;
        c_next     = '0;
        flags_next = '0;
`ifdef BF16_DIV_RNE_EN
        guard      = 1'b0;
        rnd        = 1'b0;
        sticky     = 1'b0;
`endif

        // Quotient lies in (0.5, 2): either q[9] or q[8] is the leading one.
        if (q_reg[9]) begin
            mant   = q_reg[8:2];
            e_norm = e_raw;
        end else begin
            mant   = q_reg[7:1];
            e_norm = e_raw - 10'sd1;
        end

`ifdef BF16_DIV_RNE_EN
        // After a 1-bit left shift the round position has no quotient bit;
        // the remainder still captures everything below the guard bit.
        guard  = q_reg[9] ? q_reg[1] : q_reg[0];
        rnd    = q_reg[9] ? q_reg[0] : 1'b0;
        sticky = |rem_reg;
        if (guard && (rnd || sticky || mant[0])) begin
            if (mant == 7'h7F) begin
                // 1.1111111 + ulp = 10.0000000 -> renormalise
                mant   = 7'h00;
                e_norm = e_norm + 10'sd1;
            end else begin
                mant = mant + 7'd1;
            end
        end
`endif

        if (e_norm >= 10'sd255) begin
            c_next         = {sign, BF16_PINF[14:0]};
            flags_next.ovf = 1'b1;
        end else if (e_norm <= 10'sd0) begin
            c_next         = {sign, 15'd0};
            flags_next.unf = 1'b1;
        end else begin
            c_next = {sign, e_norm[7:0], mant};
        end

        // Special operands override the arithmetic result, highest first.
        if (a_nan || b_nan) begin
            c_next             = BF16_QNAN;
            flags_next         = '0;
            flags_next.invalid = 1'b1;
        end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            c_next             = BF16_QNAN;
            flags_next         = '0;
            flags_next.invalid = 1'b1;
        end else if (b_zero && !a_inf) begin
            c_next        = {sign, BF16_PINF[14:0]};
            flags_next    = '0;
            flags_next.dz = 1'b1;
        end else if (a_inf) begin
            c_next     = {sign, BF16_PINF[14:0]};
            flags_next = '0;
        end else if (a_zero || b_inf) begin
            c_next     = {sign, 15'd0};
            flags_next = '0;
        end

        if (!en_reg) begin
            c_next     = '0;
            flags_next = '0;
        end
    end

    assign c     = c_reg;
    assign flags = flags_reg;

endmodule

// File: rtl/bf16_vec_div_seq.sv
// ---------------------------------------------------------------------------
// bf16_vec_div_seq
// N-lane sequential bfloat16 vector divider, c1[i] = a1[i] / b1[i], with a
// valid/ready handshake on both sides and a fixed 12-cycle accept-to-valid
// latency. One shared FSM (IDLE -> DIV x10 -> NORM -> DONE) sequences all
// lanes; each lane is a bf16_div_lane instance.
// Ports:
//   clk1, rst1          : clock, asynchronous active-high reset
//   in_valid, in_ready  : operand handshake (in_ready only in IDLE)
//   a1, b1              : 16*N operand buses, lane i at [16i+15:16i]
//   lane_en             : per-lane enable, sampled on accept
//   out_valid, out_ready: result handshake (result held until taken)
//   c1                  : 16*N quotient bus
//   flags               : 4*N, lane i at [4i+3:4i] = {invalid,dz,ovf,unf}
// Parameter N: lane count, 1..32.
// Build option: BF16_DIV_RNE_EN enables round-to-nearest-even in the lanes;
// latency and ports do not change.
// ---------------------------------------------------------------------------
module bf16_vec_div_seq
    import bf16_pkg::*;
#(
    parameter int N = 4
) (
    input  logic            clk1,
    input  logic            rst1,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [16*N-1:0] a1,
    input  logic [16*N-1:0] b1,
    input  logic [N-1:0]    lane_en,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [16*N-1:0] c1,
    output logic [4*N-1:0]  flags
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_DIV  = DIV;
    localparam logic [1:0] ST_NORM = NORM;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0] state_reg;
    logic [1:0] state_next;
    logic [3:0] iter_reg;
    logic [3:0] iter_next;
    logic       accept;
    logic       load;
    logic       step;
    logic       finish;

    assign in_ready  = (state_reg == ST_IDLE);
    assign out_valid = (state_reg == ST_DONE);
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_next = state_reg;
        iter_next  = iter_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_DIV;
                    iter_next  = 4'(DIV_ITERS - 1);
                end
            end
            ST_DIV: begin
                if (iter_reg == 4'd0) begin
                    state_next = ST_NORM;
                end else begin
                    iter_next = iter_reg - 4'd1;
                end
            end
            ST_NORM: begin
                state_next = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk1 or posedge rst1) begin
        if (rst1) begin
            state_reg <= ST_IDLE;
            iter_reg  <= '0;
        end else begin
            state_reg <= state_next;
            iter_reg  <= iter_next;
        end
    end

    assign load   = accept;
    assign step   = (state_reg == ST_DIV);
    assign finish = (state_reg == ST_NORM);

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            bf16_div_lane u_lane (
                .clk    (clk1),
                .rst    (rst1),
                .load   (load),
                .step   (step),
                .finish (finish),
                .a      (a1[16*gi +: 16]),
                .b      (b1[16*gi +: 16]),
                .en     (lane_en[gi]),
                .c      (c1[16*gi +: 16]),
                .flags  (flags[4*gi +: 4])
            );
        end
    endgenerate

endmodule

// File: tb/tb_bf16_vec_div_seq.sv
// ---------------------------------------------------------------------------
// tb_bf16_vec_div_seq
// Directed bench for bf16_vec_div_seq with N=4: a vector table for the
// arithmetic and special cases, plus hand-written sequences for output
// back-pressure, busy-time input, and reset in the middle of a divide.
// Honours BF16_DIV_RNE_EN for the expected values of inexact quotients.
// ---------------------------------------------------------------------------
module tb_bf16_vec_div_seq;

    localparam int N = 4;

`ifdef BF16_DIV_RNE_EN
    localparam logic [15:0] Q_THIRD_P = 16'h3EAB;
    localparam logic [15:0] Q_THIRD_N = 16'hBEAB;
    localparam logic [15:0] Q_BIG     = 16'h7F2B;
`else
    localparam logic [15:0] Q_THIRD_P = 16'h3EAA;
    localparam logic [15:0] Q_THIRD_N = 16'hBEAA;
    localparam logic [15:0] Q_BIG     = 16'h7F2A;
`endif

    logic            clk1 = 1'b0;
    logic            rst1;
    logic            in_valid;
    logic            in_ready;
    logic [16*N-1:0] a1;
    logic [16*N-1:0] b1;
    logic [N-1:0]    lane_en;
    logic            out_valid;
    logic            out_ready;
    logic [16*N-1:0] c1;
    logic [4*N-1:0]  flags;

    bf16_vec_div_seq #(.N(N)) dut (
        .clk1      (clk1),
        .rst1      (rst1),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a1        (a1),
        .b1        (b1),
        .lane_en   (lane_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c1        (c1),
        .flags     (flags)
    );

    always #5 clk1 = ~clk1;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  en;
        logic [63:0] c;
        logic [15:0] f;
    } vec_t;

    vec_t vecs [5];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Entered at the negedge of cycle 'start' after accept; leaves at the
    // negedge of the first cycle with out_valid=1 (or at the bound).
    task automatic wait_out(input int start, output int lat);
        lat = start;
        while (!out_valid && lat < 60) begin
            @(negedge clk1);
            lat++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(negedge clk1);
        out_ready = 1'b0;
        check("out_valid_fall", {63'd0, out_valid}, 64'd0);
        check("in_ready_after", {63'd0, in_ready}, 64'd1);
    endtask

    task automatic run_vec(input int idx);
        int lat;
        @(negedge clk1);
        lat = 0;
        while (!in_ready && lat < 40) begin
            @(negedge clk1);
            lat++;
        end
        check("in_ready_idle", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        a1       = vecs[idx].a;
        b1       = vecs[idx].b;
        lane_en  = vecs[idx].en;
        @(negedge clk1);
        in_valid = 1'b0;
        wait_out(1, lat);
        check($sformatf("vec%0d_latency", idx), 64'(lat), 64'd12);
        check($sformatf("vec%0d_c1", idx), c1, vecs[idx].c);
        check($sformatf("vec%0d_flags", idx), {48'd0, flags}, {48'd0, vecs[idx].f});
        $display("vec%0d: a1=%h b1=%h en=%b -> c1=%h flags=%h latency=%0d",
                 idx, vecs[idx].a, vecs[idx].b, vecs[idx].en, c1, flags, lat);
        release_out();
    endtask

    initial begin
        int lat;
        int seen;

        // lane 0 is the rightmost 16 bits
        vecs[0].a  = {16'h3F80, 16'h3F80, 16'h40C0, 16'h3F80};
        vecs[0].b  = {16'hC040, 16'h4040, 16'h4040, 16'h4000};
        vecs[0].en = 4'hF;
        vecs[0].c  = {Q_THIRD_N, Q_THIRD_P, 16'h4000, 16'h3F00};
        vecs[0].f  = 16'h0000;

        vecs[1].a  = {16'h7FC1, 16'h7F80, 16'h0000, 16'h3F80};
        vecs[1].b  = {16'h3F80, 16'h7F80, 16'h0000, 16'h0000};
        vecs[1].en = 4'hF;
        vecs[1].c  = {16'h7FC0, 16'h7FC0, 16'h7FC0, 16'h7F80};
        vecs[1].f  = 16'h8884;

        vecs[2].a  = {16'h3F80, 16'hFF80, 16'h0080, 16'h7F00};
        vecs[2].b  = {16'hFF80, 16'h4000, 16'h4000, 16'h3E80};
        vecs[2].en = 4'hF;
        vecs[2].c  = {16'h8000, 16'hFF80, 16'h0000, 16'h7F80};
        vecs[2].f  = 16'h0012;

        vecs[3].a  = {16'hC0C0, 16'h7F00, 16'h3F80, 16'h0001};
        vecs[3].b  = {16'h4000, 16'h3F40, 16'h0001, 16'h3F80};
        vecs[3].en = 4'hF;
        vecs[3].c  = {16'hC040, Q_BIG, 16'h7F80, 16'h0000};
        vecs[3].f  = 16'h0040;

        vecs[4].a  = vecs[0].a;
        vecs[4].b  = vecs[0].b;
        vecs[4].en = 4'b0101;
        vecs[4].c  = {16'h0000, Q_THIRD_P, 16'h0000, 16'h3F00};
        vecs[4].f  = 16'h0000;

        rst1      = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a1        = '0;
        b1        = '0;
        lane_en   = '0;
        repeat (3) @(negedge clk1);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_c1", c1, 64'd0);
        check("rst_flags", {48'd0, flags}, 64'd0);
        $display("reset: in_ready=%b out_valid=%b c1=%h flags=%h", in_ready, out_valid, c1, flags);
        rst1 = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_vec(i);
        end

        // Back-pressure and busy-time input: vec0 is accepted, then vec1 is
        // presented during DIV and held; it must only be taken after vec0
        // has been handed off.
        @(negedge clk1);
        in_valid = 1'b1;
        a1       = vecs[0].a;
        b1       = vecs[0].b;
        lane_en  = 4'hF;
        @(negedge clk1);
        in_valid = 1'b0;
        repeat (3) @(negedge clk1);
        in_valid = 1'b1;
        a1       = vecs[1].a;
        b1       = vecs[1].b;
        check("busy_in_ready", {63'd0, in_ready}, 64'd0);
        wait_out(4, lat);
        check("hold_latency", 64'(lat), 64'd12);
        for (int i = 0; i < 20; i++) begin
            check("hold_c1", c1, vecs[0].c);
            check("hold_flags", {48'd0, flags}, {48'd0, vecs[0].f});
            check("hold_out_valid", {63'd0, out_valid}, 64'd1);
            check("hold_in_ready", {63'd0, in_ready}, 64'd0);
            @(negedge clk1);
        end
        $display("hold: 20 cycles out_ready=0, c1=%h flags=%h", c1, flags);
        release_out();
        @(negedge clk1);
        in_valid = 1'b0;
        wait_out(1, lat);
        check("next_latency", 64'(lat), 64'd12);
        check("next_c1", c1, vecs[1].c);
        check("next_flags", {48'd0, flags}, {48'd0, vecs[1].f});
        $display("after hold: c1=%h flags=%h latency=%0d", c1, flags, lat);
        release_out();

        // Reset in cycle T+5 of a divide.
        @(negedge clk1);
        in_valid = 1'b1;
        a1       = vecs[3].a;
        b1       = vecs[3].b;
        lane_en  = 4'hF;
        @(negedge clk1);
        in_valid = 1'b0;
        repeat (4) @(negedge clk1);
        rst1 = 1'b1;
        #1;
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        check("midrst_c1", c1, 64'd0);
        check("midrst_flags", {48'd0, flags}, 64'd0);
        @(negedge clk1);
        rst1 = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk1);
            if (out_valid) seen++;
        end
        check("midrst_no_result", 64'(seen), 64'd0);
        check("midrst_c1_after", c1, 64'd0);
        $display("reset mid-DIV: out_valid cycles after release=%0d c1=%h", seen, c1);

        run_vec(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
